ps_lane_scheduler: RTL and testbench
====================================

Name: ps_lane_scheduler

Overview:
Slot scheduler that shares the single parallel-to-serial converter among 4 byte-wide lane requesters. It runs entirely on clk_32f and derives the byte-slot timing internally with a divide-by-8 counter, so the serializer no longer needs clk_4f. Each slot it grants one lane round-robin, with a bounded burst, or inserts the idle symbol. After reset or a re-enable, it emits a sync preamble of idle bytes before any grant.

Parameters:
IDLE_SYM, 8'hBC, byte loaded when no lane is granted (sync, pause, no request).
SYNC_SLOTS, 4, idle slots emitted in SYNC before entering ACTIVE (range 1..255).
MAX_BURST, 4, maximum consecutive slots one lane may hold while others are requesting (range 1..15).

Ports:
clk_32f  input  1  bit clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  scheduler run enable; sampled only at slot boundaries.
valid_in  input  4  per-lane request; bit i means lane i holds a byte.
data_in  input  32  packed lane bytes; lane i is data_in[8i+7:8i].
ready_out  output  4  one-hot consume strobe; lane i's byte is taken in that cycle.
ser_load  output  1  one-cycle pulse; serializer captures ser_data.
ser_data  output  8  byte for the serializer.
ser_valid  output  1  1 = ser_data is lane data; 0 = IDLE_SYM.
ser_lane  output  2  lane index of ser_data (0 when idle).
active  output  1  high while state == ACTIVE.

Behaviour:
- Reset (reset=1 at an edge): bit_cnt=0, state=SYNC, sync_cnt=0, ptr=0, burst_cnt=0, ser_data=IDLE_SYM, ser_valid=0, ser_lane=0, ser_load=0, active=0. ready_out is 0 whenever reset=1. Reset mid-slot aborts the slot; no byte is consumed.
- bit_cnt: 3-bit counter, increments every cycle and wraps 7->0. The boundary cycle is bit_cnt==7. After reset deasserts, the first boundary is the 8th cycle.
- At each boundary edge, ser_load<=1, so it is high during the bit_cnt==0 cycle and low otherwise. Exactly one pulse every 8 cycles.
- Grant decision happens combinationally in the boundary cycle, only in ACTIVE with enable=1:
  - Search lanes ptr, ptr+1, ... mod 4 and pick the first with valid_in set.
  - ready_out = onehot(g) in that cycle only. If no lane is valid, ready_out=0.
- Boundary edge, grant g:
  - ser_data<=data_in[g], ser_valid<=1, ser_lane<=g.
  - Burst accounting: if g==last granted lane, burst_cnt+1, else 1.
  - If the new burst_cnt==MAX_BURST, ptr<=g+1 and burst_cnt<=0; otherwise ptr<=g, so g keeps priority while its valid stays high.
- Boundary edge, no grant: ser_data<=IDLE_SYM, ser_valid<=0, ser_lane<=0, ptr unchanged, burst_cnt<=0.
- States (transitions only at boundary edges):
  - SYNC: no grants. sync_cnt increments each boundary. When sync_cnt reaches SYNC_SLOTS-1, go to ACTIVE and clear sync_cnt. So exactly SYNC_SLOTS idle loads precede the first data load.
  - ACTIVE: if enable=0 at a boundary, go to PAUSE and emit idle in that slot (no grant).
  - PAUSE: idle only. If enable=1 at a boundary, go to SYNC with sync_cnt=0; the preamble is repeated.
- enable changes between boundaries have no effect until the next boundary.
- A lane dropping valid_in mid-slot is legal; only the boundary-cycle value counts. Lane data must be stable in the boundary cycle.
- active is registered: it is 1 for every cycle where state==ACTIVE.

Test Plan:
- Reset, then enable=1, no valids -> ser_load pulses at cycles 8,16,24,...; ser_data=8'hBC, ser_valid=0 always; active rises at the 4th boundary (cycle 32).
- After sync, only lane 2 valid with data 8'hFF, then 8'hEE -> ready_out=4'b0100 at boundary cycles; ser_data=FF then EE, ser_lane=2, ser_valid=1; after MAX_BURST=4 grants with no contenders, lane 2 is still granted on the 5th slot.
- All 4 lanes always valid (bytes 8'h10,8'h21,8'h32,8'h43) -> grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,...; each lane gets 4 consecutive slots.
- Lane 0 and lane 3 valid, lane 0 drops valid after 2 grants -> third slot grants lane 3 with burst_cnt=1.
- enable=0 pulsed between boundaries only -> no state change. enable=0 held over a boundary -> idle slot, active=0. Re-enable -> 4 idle slots, then grants resume.
- reset asserted at bit_cnt==3 with lane 1 valid -> ready_out=0, outputs at reset values next cycle, no ser_valid until the full SYNC preamble completes again.

Source files
------------

// File: rtl/ps_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ps_lane_scheduler
// Description : Shares one parallel-to-serial converter among four byte-wide
//               lane requesters. Runs on clk_32f and derives byte slots with
//               an internal divide-by-8 counter. Each slot grants one lane
//               round-robin (bounded burst) or loads the idle symbol. A sync
//               preamble of idle slots precedes grants after reset/re-enable.
// Ports       : clk_32f   - bit clock, all logic on rising edge
//               reset     - synchronous active-high reset
//               enable    - run enable, sampled at slot boundaries only
//               valid_in  - per-lane request
//               data_in   - packed lane bytes, lane i at [8i+7:8i]
//               ready_out - one-hot consume strobe (boundary cycle only)
//               ser_load  - one-cycle capture pulse for the serializer
//               ser_data  - byte for the serializer
//               ser_valid - 1 when ser_data is lane data
//               ser_lane  - lane index of ser_data (0 when idle)
//               active    - high while scheduler is in ACTIVE
// Revision    : 1.0 - initial release
// ============================================================================
module ps_lane_scheduler #(
    parameter logic [7:0] IDLE_SYM   = 8'hBC,
    parameter int         SYNC_SLOTS = 4,
    parameter int         MAX_BURST  = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  valid_in,
    input  logic [31:0] data_in,
    output logic [3:0]  ready_out,
    output logic        ser_load,
    output logic [7:0]  ser_data,
    output logic        ser_valid,
    output logic [1:0]  ser_lane,
    output logic        active
);

    localparam logic [1:0] c_SYNC   = 2'd0;
    localparam logic [1:0] c_ACTIVE = 2'd1;
    localparam logic [1:0] c_PAUSE  = 2'd2;

    localparam logic [7:0] c_SYNC_LAST = 8'(SYNC_SLOTS - 1);
    localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_sync_cnt;
    logic [1:0] r_ptr;
    logic [3:0] r_burst_cnt;
    logic [1:0] r_last_lane;
    logic [7:0] r_ser_data;
    logic       r_ser_valid;
    logic [1:0] r_ser_lane;
    logic       r_ser_load;
    logic       r_active;

    logic       w_boundary;
    logic       w_sync_done;
    logic       w_found;
    logic [1:0] w_grant;
    logic [1:0] w_idx;
    logic       w_do_grant;
    logic [3:0] w_burst_new;

    assign w_boundary  = (r_bit_cnt == 3'd7);
    assign w_sync_done = (r_sync_cnt == c_SYNC_LAST);

    // Round-robin search starting at the priority pointer.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_ptr;
        w_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && valid_in[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // A zero burst count after an idle slot makes both branches yield 1.
    assign w_burst_new = (w_grant == r_last_lane) ? (r_burst_cnt + 4'd1) : 4'd1;

    // State register
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state <= c_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: transitions only on slot boundaries
    always_comb begin
        w_state_nxt = r_state;
        if (w_boundary) begin
            case (r_state)
                c_SYNC:   if (w_sync_done) w_state_nxt = c_ACTIVE;
                c_ACTIVE: if (!enable)     w_state_nxt = c_PAUSE;
                c_PAUSE:  if (enable)      w_state_nxt = c_SYNC;
                default:                   w_state_nxt = c_SYNC;
            endcase
        end
    end

    // Output logic: grant strobe exists only in the boundary cycle
    always_comb begin
        w_do_grant = 1'b0;
        ready_out  = 4'b0000;
        if (!reset && w_boundary && (r_state == c_ACTIVE) && enable && w_found) begin
            w_do_grant = 1'b1;
            ready_out  = 4'b0001 << w_grant;
        end
    end

    // Slot timing, serializer byte and arbitration bookkeeping
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_bit_cnt   <= 3'd0;
            r_sync_cnt  <= 8'd0;
            r_ptr       <= 2'd0;
            r_burst_cnt <= 4'd0;
            r_last_lane <= 2'd0;
            r_ser_data  <= IDLE_SYM;
            r_ser_valid <= 1'b0;
            r_ser_lane  <= 2'd0;
            r_ser_load  <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_ser_load <= w_boundary;
            r_active   <= (w_state_nxt == c_ACTIVE);
            if (w_boundary) begin
                if (w_do_grant) begin
                    r_ser_data  <= data_in[{w_grant, 3'b000} +: 8];
                    r_ser_valid <= 1'b1;
                    r_ser_lane  <= w_grant;
                    r_last_lane <= w_grant;
                    // Holding the pointer on the granted lane keeps its
                    // priority until the burst limit hands it onward.
                    if (w_burst_new == c_MAX_BURST) begin
                        r_ptr       <= w_grant + 2'd1;
                        r_burst_cnt <= 4'd0;
                    end else begin
                        r_ptr       <= w_grant;
                        r_burst_cnt <= w_burst_new;
                    end
                end else begin
                    r_ser_data  <= IDLE_SYM;
                    r_ser_valid <= 1'b0;
                    r_ser_lane  <= 2'd0;
                    r_burst_cnt <= 4'd0;
                end
                if (r_state == c_SYNC) begin
                    r_sync_cnt <= w_sync_done ? 8'd0 : (r_sync_cnt + 8'd1);
                end else if ((r_state == c_PAUSE) && enable) begin
                    r_sync_cnt <= 8'd0;
                end
            end
        end
    end

    assign ser_load  = r_ser_load;
    assign ser_data  = r_ser_data;
    assign ser_valid = r_ser_valid;
    assign ser_lane  = r_ser_lane;
    assign active    = r_active;

endmodule
`default_nettype wire

// File: tb/tb_ps_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps_lane_scheduler
// Description : Randomized self-checking bench for ps_lane_scheduler with a
//               slot-level behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps_lane_scheduler;

    localparam logic [7:0] c_IDLE  = 8'hBC;
    localparam int         c_SYNCN = 4;
    localparam int         c_MAXB  = 4;
    localparam int         c_CYC   = 240;

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic [3:0]  valid_in = 4'b0000;
    logic [31:0] data_in  = 32'h0;
    logic [3:0]  ready_out;
    logic        ser_load;
    logic [7:0]  ser_data;
    logic        ser_valid;
    logic [1:0]  ser_lane;
    logic        active;

    ps_lane_scheduler #(
        .IDLE_SYM   (c_IDLE),
        .SYNC_SLOTS (c_SYNCN),
        .MAX_BURST  (c_MAXB)
    ) u_dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .enable    (enable),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .ser_load  (ser_load),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_lane  (ser_lane),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles since reset, mode name, preamble slots seen,
    // priority lane, current streak of the last granted lane.
    int         m_cycles;
    string      m_mode;
    int         m_syncs;
    int         m_ptr;
    int         m_streak;
    int         m_last;
    logic [7:0] e_data;
    logic       e_valid;
    int         e_lane;
    logic       e_load;
    logic       e_active;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_lane(input logic [3:0] v, input int from);
        for (int k = 0; k < 4; k++) begin
            if (v[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    function automatic bit at_boundary();
        return (m_cycles % 8) == 7;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        if (reset || !at_boundary() || m_mode != "ACTIVE" || !enable) return 4'b0000;
        g = pick_lane(valid_in, m_ptr);
        if (g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    // Advances the model across one rising edge using the current inputs.
    task automatic model_step();
        int g;
        if (reset) begin
            m_cycles = 0; m_mode = "SYNC"; m_syncs = 0;
            m_ptr = 0; m_streak = 0; m_last = 0;
            e_data = c_IDLE; e_valid = 1'b0; e_lane = 0;
            e_load = 1'b0; e_active = 1'b0;
            return;
        end
        e_load = at_boundary();
        if (at_boundary()) begin
            g = (m_mode == "ACTIVE" && enable) ? pick_lane(valid_in, m_ptr) : -1;
            if (g >= 0) begin
                e_data  = data_in[8*g +: 8];
                e_valid = 1'b1;
                e_lane  = g;
                m_streak = (g == m_last) ? m_streak + 1 : 1;
                m_last   = g;
                if (m_streak == c_MAXB) begin
                    m_ptr = (g + 1) % 4;
                    m_streak = 0;
                end else begin
                    m_ptr = g;
                end
            end else begin
                e_data = c_IDLE; e_valid = 1'b0; e_lane = 0;
                m_streak = 0;
            end
            if (m_mode == "SYNC") begin
                m_syncs++;
                if (m_syncs == c_SYNCN) begin
                    m_mode = "ACTIVE";
                    m_syncs = 0;
                end
            end else if (m_mode == "ACTIVE") begin
                if (!enable) m_mode = "PAUSE";
            end else if (enable) begin
                m_mode = "SYNC";
                m_syncs = 0;
            end
        end
        m_cycles++;
        e_active = (m_mode == "ACTIVE");
    endtask

    initial begin
        logic [3:0]  fixed_v;
        logic [3:0]  rand_v;
        logic [31:0] fixed_d;
        bit          rnd_data;
        bit          rst_pending;

        reset = 1'b1;
        repeat (2) @(posedge clk_32f);
        model_step();

        for (int seg = 0; seg < 6; seg++) begin
            rnd_data    = 1'b1;
            fixed_d     = 32'h0;
            rand_v      = 4'b0000;
            rst_pending = 1'b0;
            case (seg)
                0: fixed_v = 4'b0000;
                1: begin fixed_v = 4'b0100; rand_v = 4'b0000; end
                2: begin fixed_v = 4'b1111; rnd_data = 1'b0; fixed_d = 32'h4332_2110; end
                3: begin fixed_v = 4'b0010; rand_v = 4'b1101; rst_pending = 1'b1; end
                4: begin fixed_v = 4'b1001; rand_v = 4'b0110; end
                default: begin fixed_v = 4'b0000; rand_v = 4'b1111; end
            endcase
            for (int cyc = 0; cyc < c_CYC; cyc++) begin
                @(negedge clk_32f);
                if (rst_pending && m_cycles > 60 && (m_cycles % 8) == 3) begin
                    reset = 1'b1;
                    rst_pending = 1'b0;
                end else begin
                    reset = (seg >= 4) && ($urandom_range(0, 299) == 0);
                end
                if (seg < 3) enable = 1'b1;
                else if (seg == 4) enable = !(cyc >= 120 && cyc < 150);
                else enable = ($urandom_range(0, 11) != 0);
                valid_in = fixed_v | (4'($urandom) & rand_v);
                if (seg == 1) data_in = (m_cycles % 16 < 8) ? 32'h00FF_0000 : 32'h00EE_0000;
                else data_in = rnd_data ? $urandom : fixed_d;
                #1;
                chk("ready_out", {28'h0, ready_out}, {28'h0, exp_ready()});
                chk("ser_load", {31'h0, ser_load}, {31'h0, e_load});
                chk("ser_data", {24'h0, ser_data}, {24'h0, e_data});
                chk("ser_valid", {31'h0, ser_valid}, {31'h0, e_valid});
                chk("ser_lane", {30'h0, ser_lane}, 32'(e_lane));
                chk("active", {31'h0, active}, {31'h0, e_active});
                model_step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
